// File: rtl/vliw_packer.sv
`default_nettype none
// ============================================================================
//  Module   : vliw_packer
//  Purpose  : Collects per-core instructions one at a time over a valid/ready
//             handshake and assembles them into a single VLIW bundle, which is
//             then offered downstream over a second valid/ready handshake.
//             Slot 0 occupies the most-significant INST_LEN bits, matching the
//             bundle layout expected by the VLIW splitter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CORES      number of instruction slots per bundle (>= 1)
//    INST_LEN   width of one instruction in bits
//    NOP        pad value written into slots left unfilled by an early close
//  Ports
//    clk          in   rising-edge clock
//    reset        in   synchronous active-high reset
//    inst_in      in   instruction for the next free slot
//    inst_valid   in   inst_in is valid
//    inst_last    in   inst_in closes the bundle early
//    inst_ready   out  packer accepts an instruction this cycle
//    vliw_out     out  assembled bundle (slot i at the i-th field from the MSB)
//    vliw_valid   out  vliw_out holds a complete bundle
//    vliw_ready   in   consumer accepts the bundle
//    slots_used   out  number of real (non-pad) instructions in the bundle
// ============================================================================
module vliw_packer #(
  parameter int                     CORES    = 4,
  parameter int                     INST_LEN = 32,
  parameter logic [INST_LEN-1:0]    NOP      = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INST_LEN-1:0]         inst_in,
  input  logic                        inst_valid,
  input  logic                        inst_last,
  output logic                        inst_ready,
  output logic [CORES*INST_LEN-1:0]   vliw_out,
  output logic                        vliw_valid,
  input  logic                        vliw_ready,
  output logic [$clog2(CORES+1)-1:0]  slots_used
);

  localparam int PTR_W  = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int USED_W = $clog2(CORES+1);

  localparam logic [0:0] c_FILL = 1'b0;
  localparam logic [0:0] c_HOLD = 1'b1;

  localparam logic [PTR_W-1:0]          c_LAST_PTR = PTR_W'(CORES-1);
  localparam logic [CORES*INST_LEN-1:0] c_EMPTY    = {CORES{NOP}};

  logic [0:0]                r_state;
  logic [0:0]                w_state_nxt;
  logic [PTR_W-1:0]          r_ptr;
  logic [CORES*INST_LEN-1:0] r_vliw;
  logic [USED_W-1:0]         r_used;

  logic w_inst_ready;
  logic w_vliw_valid;
  logic w_accept;
  logic w_close;
  logic w_drain;

  // Acceptance is only possible in FILL, so HOLD and the drain cycle itself
  // ignore inst_valid entirely.
  assign w_accept = inst_valid && (r_state == c_FILL);
  assign w_close  = w_accept && (inst_last || (r_ptr == c_LAST_PTR));
  assign w_drain  = (r_state == c_HOLD) && vliw_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_FILL:  if (w_close) w_state_nxt = c_HOLD;
      c_HOLD:  if (vliw_ready) w_state_nxt = c_FILL;
      default: w_state_nxt = c_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: handshake flags come straight from the state register, so
  // both are glitch-free registered outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    w_inst_ready = 1'b0;
    w_vliw_valid = 1'b0;
    case (r_state)
      c_FILL:  w_inst_ready = 1'b1;
      c_HOLD:  w_vliw_valid = 1'b1;
      default: w_inst_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot datapath. The bundle register is pre-loaded with NOP in every slot
  // on reset and on drain, so an early close needs no separate pad step:
  // untouched slots already hold NOP.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vliw <= c_EMPTY;
      r_ptr  <= '0;
      r_used <= '0;
    end else if (w_drain) begin
      r_vliw <= c_EMPTY;
      r_ptr  <= '0;
      r_used <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < CORES; i++) begin
        if (r_ptr == PTR_W'(i)) begin
          r_vliw[(CORES-i)*INST_LEN-1 -: INST_LEN] <= inst_in;
        end
      end
      if (w_close) begin
        // Pointer parks on the closing slot; it is rewound only by the drain.
        r_used <= USED_W'(r_ptr) + USED_W'(1);
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end

  assign inst_ready = w_inst_ready;
  assign vliw_valid = w_vliw_valid;
  assign vliw_out   = r_vliw;
  assign slots_used = r_used;

endmodule
`default_nettype wire

// File: tb/tb_vliw_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vliw_packer
//  Purpose  : Self-checking bench for vliw_packer. Three instances cover
//             CORES=2 (NOP=0), CORES=4 (NOP=all ones) and CORES=1. Expected
//             bundles are queued when stimulus is driven and compared when a
//             bundle appears on the DUT output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vliw_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 = CORES 2, 1 = CORES 4, 2 = CORES 1
  logic        rst   [3];
  logic [31:0] din   [3];
  logic        dval  [3];
  logic        dlast [3];
  logic        vrdy  [3];

  wire         irdy [3];
  wire         vval [3];
  wire [127:0] vout [3];
  wire [2:0]   used [3];

  wire [63:0]  out_c2;
  wire [127:0] out_c4;
  wire [31:0]  out_c1;
  wire [1:0]   used_c2;
  wire [2:0]   used_c4;
  wire [0:0]   used_c1;

  assign vout[0] = {64'h0, out_c2};
  assign vout[1] = out_c4;
  assign vout[2] = {96'h0, out_c1};
  assign used[0] = {1'b0, used_c2};
  assign used[1] = used_c4;
  assign used[2] = {2'b0, used_c1};

  vliw_packer #(.CORES(2), .INST_LEN(32), .NOP(32'h0)) u_c2 (
    .clk(clk), .reset(rst[0]), .inst_in(din[0]), .inst_valid(dval[0]),
    .inst_last(dlast[0]), .inst_ready(irdy[0]), .vliw_out(out_c2),
    .vliw_valid(vval[0]), .vliw_ready(vrdy[0]), .slots_used(used_c2));

  vliw_packer #(.CORES(4), .INST_LEN(32), .NOP(32'hFFFFFFFF)) u_c4 (
    .clk(clk), .reset(rst[1]), .inst_in(din[1]), .inst_valid(dval[1]),
    .inst_last(dlast[1]), .inst_ready(irdy[1]), .vliw_out(out_c4),
    .vliw_valid(vval[1]), .vliw_ready(vrdy[1]), .slots_used(used_c4));

  vliw_packer #(.CORES(1), .INST_LEN(32), .NOP(32'h0)) u_c1 (
    .clk(clk), .reset(rst[2]), .inst_in(din[2]), .inst_valid(dval[2]),
    .inst_last(dlast[2]), .inst_ready(irdy[2]), .vliw_out(out_c1),
    .vliw_valid(vval[2]), .vliw_ready(vrdy[2]), .slots_used(used_c1));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    int           k;
    logic [127:0] out;
    logic [2:0]   used;
  } exp_t;
  exp_t sbq[$];

  task automatic push_exp(input int k, input logic [127:0] out, input logic [2:0] u);
    exp_t e;
    e.k = k; e.out = out; e.used = u;
    sbq.push_back(e);
  endtask

  // Monitor: each new bundle (rising vliw_valid) is checked against the queue.
  logic prev_v [3];
  initial for (int k = 0; k < 3; k++) prev_v[k] = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vval[k] === 1'b1 && prev_v[k] !== 1'b1) begin
        if (sbq.size() == 0) begin
          check($sformatf("unexpected_bundle_%0d", k), 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check($sformatf("sb_inst_%0d", k), 128'(k), 128'(e.k));
          check($sformatf("sb_out_%0d", k), vout[k], e.out);
          check($sformatf("sb_used_%0d", k), 128'(used[k]), 128'(e.used));
        end
      end
      prev_v[k] = vval[k];
    end
  end

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[k] = 1'b0;
  endtask

  // Drive one instruction and wait (bounded) for it to be accepted.
  task automatic send(input int k, input logic [31:0] d, input logic last);
    bit done = 0;
    din[k] = d; dval[k] = 1'b1; dlast[k] = last;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (irdy[k] === 1'b1) done = 1;
      @(posedge clk);
    end
    #1;
    dval[k] = 1'b0; dlast[k] = 1'b0;
    if (!done) check("accept_timeout", 128'd0, 128'd1);
  endtask

  // Handshake the held bundle; caller must be in HOLD.
  task automatic drain(input int k);
    vrdy[k] = 1'b1;
    @(posedge clk);
    #1 vrdy[k] = 1'b0;
  endtask

  logic [127:0] snap;
  logic [127:0] rexp;
  logic [31:0]  rd;
  int           rn;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; din[k] = '0; dval[k] = 1'b0; dlast[k] = 1'b0; vrdy[k] = 1'b0;
    end
    // Reset asserted together with valid inputs must still win.
    dval[0] = 1'b1; din[0] = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    dval[0] = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    check("rst_valid_c2", 128'(vval[0]), 128'd0);
    check("rst_ready_c2", 128'(irdy[0]), 128'd1);
    check("rst_out_c2",   vout[0], 128'h0);
    check("rst_used_c2",  128'(used[0]), 128'd0);
    check("rst_out_c4",   vout[1], {4{32'hFFFFFFFF}});
    @(posedge clk); #1;

    // ---- CORES=2 full bundle, long hold ----
    push_exp(0, {64'h0, 64'h0000827D_00009A12}, 3'd2);
    send(0, 32'h0000827D, 1'b0);
    @(negedge clk);
    check("c2_mid_valid", 128'(vval[0]), 128'd0);
    check("c2_mid_ready", 128'(irdy[0]), 128'd1);
    @(posedge clk); #1;
    send(0, 32'h00009A12, 1'b0);
    @(negedge clk);
    check("c2_lat_valid", 128'(vval[0]), 128'd1);
    check("c2_lat_ready", 128'(irdy[0]), 128'd0);
    check("c2_lat_out",   vout[0], {64'h0, 64'h0000827D_00009A12});
    check("c2_lat_used",  128'(used[0]), 128'd2);
    // instruction offered during HOLD must be ignored
    din[0] = 32'hDEADBEEF; dval[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("c2_hold_valid", 128'(vval[0]), 128'd1);
      check("c2_hold_out",   vout[0], {64'h0, 64'h0000827D_00009A12});
      check("c2_hold_used",  128'(used[0]), 128'd2);
    end
    @(posedge clk); #1;
    drain(0);           // inst_valid still high in the drain cycle
    dval[0] = 1'b0;
    @(negedge clk);
    check("c2_drain_valid", 128'(vval[0]), 128'd0);
    check("c2_drain_ready", 128'(irdy[0]), 128'd1);
    check("c2_drain_out",   vout[0], 128'h0);
    check("c2_drain_used",  128'(used[0]), 128'd0);
    @(posedge clk); #1;

    // ---- CORES=4 full bundle ----
    push_exp(1, 128'h00008A2B_000052C6_00007112_00006F5A, 3'd4);
    send(1, 32'h8A2B, 1'b0);
    send(1, 32'h52C6, 1'b0);
    send(1, 32'h7112, 1'b0);
    send(1, 32'h6F5A, 1'b0);
    @(negedge clk);
    check("c4_full_valid", 128'(vval[1]), 128'd1);
    @(posedge clk); #1;
    drain(1);

    // ---- CORES=4 early close, NOP padding, HOLD ignores inst_valid ----
    push_exp(1, 128'h00001111_00002222_FFFFFFFF_FFFFFFFF, 3'd2);
    send(1, 32'h1111, 1'b0);
    send(1, 32'h2222, 1'b1);
    din[1] = 32'hBAD0BAD0; dval[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("c4_hold_ready", 128'(irdy[1]), 128'd0);
      check("c4_hold_out",   vout[1], 128'h00001111_00002222_FFFFFFFF_FFFFFFFF);
    end
    dval[1] = 1'b0;
    @(posedge clk); #1;
    drain(1);

    // ---- inst_last without inst_valid, vliw_ready in FILL: no effect ----
    dlast[1] = 1'b1; vrdy[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 dlast[1] = 1'b0; vrdy[1] = 1'b0;
    @(negedge clk);
    check("c4_idle_valid", 128'(vval[1]), 128'd0);
    check("c4_idle_ready", 128'(irdy[1]), 128'd1);
    @(posedge clk); #1;

    // ---- reset discards partial bundle ----
    send(1, 32'hA1, 1'b0);
    send(1, 32'hA2, 1'b0);
    send(1, 32'hA3, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("c4_rst_valid", 128'(vval[1]), 128'd0);
    check("c4_rst_out",   vout[1], {4{32'hFFFFFFFF}});
    @(posedge clk); #1;
    push_exp(1, 128'h000000B1_000000B2_000000B3_000000B4, 3'd4);
    send(1, 32'hB1, 1'b0);
    send(1, 32'hB2, 1'b0);
    send(1, 32'hB3, 1'b0);
    send(1, 32'hB4, 1'b0);
    @(negedge clk);
    check("c4_fresh_valid", 128'(vval[1]), 128'd1);
    @(posedge clk); #1;
    drain(1);

    // ---- CORES=1 ----
    push_exp(2, 128'h0000C6BD, 3'd1);
    send(2, 32'h0000C6BD, 1'b0);
    @(negedge clk);
    check("c1_valid", 128'(vval[2]), 128'd1);
    check("c1_out",   vout[2], 128'h0000C6BD);
    check("c1_used",  128'(used[2]), 128'd1);
    @(posedge clk); #1;
    drain(2);

    // ---- CORES=4 random bundles of random length ----
    for (int b = 0; b < 8; b++) begin
      rn   = $urandom_range(1, 4);
      rexp = {4{32'hFFFFFFFF}};
      for (int j = 0; j < rn; j++) rexp[(4-j)*32-1 -: 32] = 32'(b * 16 + j + 1) ^ 32'h5A000000;
      push_exp(1, rexp, 3'(rn));
      for (int j = 0; j < rn; j++) begin
        rd = 32'(b * 16 + j + 1) ^ 32'h5A000000;
        send(1, rd, (j == rn - 1) ? 1'b1 : 1'b0);
      end
      snap = rexp;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      @(negedge clk);
      check("rnd_hold_out", vout[1], snap);
      @(posedge clk); #1;
      drain(1);
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 128'(sbq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
